// File: rtl/count_seq_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | count_chk_pkg : state encoding for the count sequence checker      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package count_chk_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/count_seq_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | count_seq_checker_if : observed count bus (valid strobe + value)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface count_seq_checker_if
    import count_chk_pkg::*;
#(
    parameter int W = 4
) ();
    logic         count_valid;
    logic [W-1:0] count_in;

    modport master (output count_valid, output count_in);
    modport slave  (input  count_valid, input  count_in);
endinterface
`default_nettype wire

// File: rtl/count_seq_checker_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : enable-driven counter that holds at all-ones         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sat_counter #(
    parameter int ECW = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           clear,
    input  wire logic           inc,
    output logic [ECW-1:0]      count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {ECW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | count_seq_checker : locks onto an incrementing count stream and    |
// | flags every break in it. Rev 1.0                                   |
// +--------------------------------------------------------------------+
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int          W            = 4,
    parameter int          LOCK_LEN     = 3,
    parameter int          ECW          = 8,
    parameter int unsigned ZERO_RESTART = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           clear,
    count_seq_checker_if.slave  cnt,
    output logic                locked,
    output logic                err_pulse,
    output logic                restart_pulse,
    output logic [ECW-1:0]      err_count,
    output logic [W-1:0]        expected
);

    localparam int RW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_LEN - 1);

    chk_state_t    state, state_nxt;
    logic [RW-1:0] run, run_nxt;
    logic          locked_nxt, err_nxt, restart_nxt, err_inc;
    logic [W-1:0]  expected_nxt;
    logic          match;

    assign match = (cnt.count_in == expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= UNSYNC;
            run           <= '0;
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            restart_pulse <= 1'b0;
            expected      <= '0;
        end else begin
            state         <= state_nxt;
            run           <= run_nxt;
            locked        <= locked_nxt;
            err_pulse     <= err_nxt;
            restart_pulse <= restart_nxt;
            expected      <= expected_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        run_nxt      = run;
        locked_nxt   = locked;
        err_nxt      = 1'b0;
        restart_nxt  = 1'b0;
        err_inc      = 1'b0;
        expected_nxt = expected;

        if (clear) begin
            state_nxt    = UNSYNC;
            run_nxt      = '0;
            locked_nxt   = 1'b0;
            expected_nxt = '0;
        end else if (cnt.count_valid) begin
            expected_nxt = cnt.count_in + 1'b1;
            case (state)
                UNSYNC: begin
                    state_nxt = SYNC;
                    run_nxt   = '0;
                end
                SYNC: begin
                    if (!match) begin
                        run_nxt = '0;
                    end else if (run == RUN_LAST) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                        run_nxt    = '0;
                    end else begin
                        run_nxt = run + 1'b1;
                    end
                end
                LOCKED: begin
                    // A zero while locked is taken as the source counter restarting
                    if (match) begin
                        state_nxt = LOCKED;
                    end else if ((ZERO_RESTART != 0) && (cnt.count_in == '0)) begin
                        restart_nxt = 1'b1;
                    end else begin
                        err_nxt    = 1'b1;
                        err_inc    = 1'b1;
                        locked_nxt = 1'b0;
                        state_nxt  = SYNC;
                        run_nxt    = '0;
                    end
                end
                default: begin
                    state_nxt  = UNSYNC;
                    run_nxt    = '0;
                    locked_nxt = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .ECW (ECW)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// Bench: three checker variants (default, ZERO_RESTART=0, ECW=2) share one
// count bus and are compared against a sample-level reference model.
module tb_count_seq_checker;

    localparam int LOCK_LEN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    count_seq_checker_if #(.W(4)) bus ();

    logic [2:0] lk, ep, rp;
    logic [7:0] ec [3];
    logic [3:0] ex [3];
    logic [1:0] ec2;
    assign ec[2] = {6'b0, ec2};

    count_seq_checker #(.W(4), .LOCK_LEN(LOCK_LEN), .ECW(8), .ZERO_RESTART(1)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .cnt(bus.slave),
        .locked(lk[0]), .err_pulse(ep[0]), .restart_pulse(rp[0]),
        .err_count(ec[0]), .expected(ex[0]));
    count_seq_checker #(.W(4), .LOCK_LEN(LOCK_LEN), .ECW(8), .ZERO_RESTART(0)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .cnt(bus.slave),
        .locked(lk[1]), .err_pulse(ep[1]), .restart_pulse(rp[1]),
        .err_count(ec[1]), .expected(ex[1]));
    count_seq_checker #(.W(4), .LOCK_LEN(LOCK_LEN), .ECW(2), .ZERO_RESTART(1)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .cnt(bus.slave),
        .locked(lk[2]), .err_pulse(ep[2]), .restart_pulse(rp[2]),
        .err_count(ec2), .expected(ex[2]));

    int checks = 0;
    int failures = 0;

    // Reference model: per-variant view of the stream in terms of samples
    int zr    [3] = '{1, 0, 1};
    int ecmax [3] = '{255, 255, 3};
    bit m_seen [3];
    int m_streak [3];
    bit m_lock [3];
    int m_exp [3];
    int m_ec [3];
    bit m_ep [3];
    bit m_rp [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_seen[i] = 0; m_streak[i] = 0; m_lock[i] = 0;
            m_exp[i] = 0; m_ec[i] = 0; m_ep[i] = 0; m_rp[i] = 0;
        end
    endtask

    task automatic model_clk(input bit v, input int d, input bit clr);
        for (int i = 0; i < 3; i++) begin
            m_ep[i] = 0;
            m_rp[i] = 0;
            if (clr) begin
                m_seen[i] = 0; m_streak[i] = 0; m_lock[i] = 0;
                m_exp[i] = 0; m_ec[i] = 0;
            end else if (v) begin
                if (!m_seen[i]) begin
                    m_seen[i] = 1;
                    m_streak[i] = 0;
                end else if (!m_lock[i]) begin
                    if (d == m_exp[i]) begin
                        m_streak[i]++;
                        if (m_streak[i] >= LOCK_LEN) begin
                            m_lock[i] = 1;
                            m_streak[i] = 0;
                        end
                    end else begin
                        m_streak[i] = 0;
                    end
                end else if (d != m_exp[i]) begin
                    if (d == 0 && zr[i] != 0) begin
                        m_rp[i] = 1;
                    end else begin
                        m_ep[i] = 1;
                        if (m_ec[i] < ecmax[i]) m_ec[i]++;
                        m_lock[i] = 0;
                        m_streak[i] = 0;
                    end
                end
                m_exp[i] = (d + 1) % 16;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_u%0d_locked", tag, i), {31'b0, lk[i]}, m_lock[i]);
            chk($sformatf("%s_u%0d_err_pulse", tag, i), {31'b0, ep[i]}, m_ep[i]);
            chk($sformatf("%s_u%0d_restart", tag, i), {31'b0, rp[i]}, m_rp[i]);
            chk($sformatf("%s_u%0d_err_count", tag, i), {24'b0, ec[i]}, m_ec[i]);
            chk($sformatf("%s_u%0d_expected", tag, i), {28'b0, ex[i]}, m_exp[i]);
        end
    endtask

    task automatic step(input bit v, input int d, input bit clr, input string tag);
        @(negedge clk);
        bus.count_valid = v;
        bus.count_in    = 4'(d);
        clear           = clr;
        @(posedge clk);
        model_clk(v, d, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        int b, r, d;
        bit v, c;
        bus.count_valid = 1'b0;
        bus.count_in    = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Initial lock on 5,6,7,8
        for (int k = 5; k <= 8; k++) step(1, k, 0, "lock");
        chk("t1_locked", {31'b0, lk[0]}, 1);
        chk("t1_expected", {28'b0, ex[0]}, 9);
        chk("t1_err_count", {24'b0, ec[0]}, 0);

        // Wrap F -> 0 is a correct increment
        for (int k = 9; k <= 17; k++) step(1, k % 16, 0, "wrap");
        chk("t2_expected", {28'b0, ex[0]}, 2);
        chk("t2_err_count", {24'b0, ec[0]}, 0);

        // Skip while locked, then relock
        step(1, 2, 0, "pre_skip");
        step(1, 3, 0, "pre_skip");
        step(1, 5, 0, "skip");
        chk("t3_err_pulse", {31'b0, ep[0]}, 1);
        chk("t3_err_count", {24'b0, ec[0]}, 1);
        chk("t3_unlocked", {31'b0, lk[0]}, 0);
        step(0, 0, 0, "skip_idle");
        chk("t3_pulse_gone", {31'b0, ep[0]}, 0);
        for (int k = 6; k <= 8; k++) step(1, k, 0, "relock");
        chk("t3_relocked", {31'b0, lk[0]}, 1);

        // Zero restart vs zero-as-error
        step(0, 0, 1, "clear");
        for (int k = 5; k <= 9; k++) step(1, k, 0, "zr_lock");
        step(1, 0, 0, "zero");
        chk("t4_restart", {31'b0, rp[0]}, 1);
        chk("t4_locked_kept", {31'b0, lk[0]}, 1);
        chk("t4_ec_zr1", {24'b0, ec[0]}, 0);
        chk("t4_err_zr0", {31'b0, ep[1]}, 1);
        chk("t4_ec_zr0", {24'b0, ec[1]}, 1);

        // Saturation of the 2-bit error counter
        for (int k = 0; k < 4; k++) begin
            b = (m_exp[0] + 2) % 16;
            if (b == 0) b = 3;
            step(1, b, 0, "break");
            for (int j = 1; j <= 3; j++) step(1, (b + j) % 16, 0, "break_relock");
        end
        chk("t5_ec2_sat", {24'b0, ec[2]}, 3);
        chk("t5_ec0_four", {24'b0, ec[0]}, 4);
        step(1, m_exp[0], 1, "clear_valid");
        chk("t5_clr_ec", {24'b0, ec[2]}, 0);
        chk("t5_clr_exp", {28'b0, ex[2]}, 0);
        chk("t5_clr_lock", {31'b0, lk[0]}, 0);

        // Relock, then samples separated by idle cycles
        for (int k = 7; k <= 10; k++) step(1, k, 0, "gap_lock");
        step(0, 3, 0, "gap"); step(1, 11, 0, "gap");
        step(0, 0, 0, "gap"); step(0, 9, 0, "gap"); step(1, 12, 0, "gap");
        step(0, 1, 0, "gap"); step(1, 13, 0, "gap");
        chk("t6_gap_locked", {31'b0, lk[0]}, 1);
        chk("t6_gap_ec", {24'b0, ec[0]}, 0);

        // Asynchronous reset between two samples
        @(negedge clk);
        bus.count_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 4, 0, "post_rst");
        chk("t6_post_rst_lock", {31'b0, lk[0]}, 0);
        chk("t6_post_rst_exp", {28'b0, ex[0]}, 5);
        for (int k = 5; k <= 7; k++) step(1, k, 0, "post_rst_lock");
        chk("t6_post_rst_relock", {31'b0, lk[0]}, 1);

        // Randomized stream biased toward the expected sequence
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7)      d = m_exp[0];
            else if (r < 8) d = 0;
            else            d = $urandom_range(0, 15);
            c = ($urandom_range(0, 59) == 0);
            step(v, d, c, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
